// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    VALID
  } ifu_state_t;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ifu.sv
// Instruction fetch: one word per core PC, REQ -> WAIT -> VALID, 3 cycles per insn on zero-wait memory.
// Request held until mem_req_ready; instruction held until cmd_ack; misaligned PC yields a flagged NOP.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] cmd,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic        fetch_misalign,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] fetch_count
);

  ifu_state_t  state;
  logic [31:0] cmd_q;
  logic        misalign_q;
  logic        pc_aligned;
  logic        unused_reset_pc;

  // RESET_PC lives in the core's PC register; it is only carried here for the bench.
  assign unused_reset_pc = ^RESET_PC;

  assign pc_aligned     = (pc[1:0] == 2'b00);
  assign mem_req_valid  = (state == REQ) && pc_aligned;
  assign mem_req_addr   = {pc[31:2], 2'b00};
  assign cmd_valid      = (state == VALID);
  assign cmd            = cmd_valid ? cmd_q : NOP;
  assign fetch_misalign = cmd_valid && misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      cmd_q       <= NOP;
      misalign_q  <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (!pc_aligned) begin
            cmd_q      <= NOP;
            misalign_q <= 1'b1;
            state      <= VALID;
          end else if (mem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            cmd_q      <= mem_resp_data;
            misalign_q <= 1'b0;
            state      <= VALID;
          end
        end
        VALID: begin
          if (cmd_ack) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Randomized bench for ifu against a transaction-level model of core, memory and fetch expectations.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RPC = RESET_PC_DEFAULT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ack;
  logic        fetch_misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] fetch_count;

  ifu #(.RESET_PC(RPC), .NOP(NOP_INSN)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .cmd_ack       (cmd_ack),
    .fetch_misalign(fetch_misalign),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0093;
  endfunction

  // Reference model: what the core/memory pair has seen so far, in transaction terms.
  logic [31:0] cur_pc = RPC;
  logic [31:0] held = NOP_INSN;
  logic [31:0] exp_cnt = '0;
  bit          insn_ready = 1'b0;
  bit          accepted = 1'b0;
  int          resp_at = -1;
  int          cyc = 0;
  int          req_age = 0, val_age = 0, acc_cnt = 0, req_hi = 0;
  int          commits = 0, last_commit = 0;

  // Stimulus knobs
  int          k_rdy = 0, k_rsp = 0, k_ack = 0, spur_pct = 0;
  bit          k_rand = 1'b0, k_rst_on_resp = 1'b0, k_data_en = 1'b0, rst_req = 1'b1;
  bit          pc_fixed = 1'b0, saw_rst = 1'b0;
  logic [31:0] k_data = '0, pc_next = '0;

  task automatic pick_next_pc();
    int r;
    if (pc_fixed) begin
      cur_pc = pc_next;
    end else begin
      r = $urandom_range(9);
      if (r < 6)      cur_pc = {cur_pc[31:2], 2'b00} + 32'd4;
      else if (r < 8) cur_pc = {$urandom} & ~32'h3;
      else            cur_pc = ({$urandom} & ~32'h3) | 32'($urandom_range(1, 3));
    end
    if (k_rand) begin
      k_rdy = $urandom_range(0, 3);
      k_rsp = $urandom_range(0, 4);
      k_ack = $urandom_range(0, 3);
    end
  endtask

  task automatic tick(input bit do_chk);
    logic        rsp_real;
    logic        exp_req;
    logic [31:0] data;
    @(negedge clk);
    rsp_real = (resp_at == cyc);
    rst = rst_req || (k_rst_on_resp && rsp_real) || (k_rand && $urandom_range(299) == 0);
    if (rst && k_rst_on_resp && rsp_real) saw_rst = 1'b1;
    pc = cur_pc;
    mem_req_ready = (req_age >= k_rdy);
    data = k_data_en ? k_data : mem_word({cur_pc[31:2], 2'b00});
    mem_resp_valid = rsp_real;
    mem_resp_data  = rsp_real ? data : $urandom;
    if (!rsp_real && insn_ready && $urandom_range(99) < spur_pct) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h1234_5678;
    end
    cmd_ack = insn_ready ? (val_age >= k_ack) : ($urandom_range(3) == 0);
    #1;
    exp_req = !insn_ready && !accepted && (cur_pc[1:0] == 2'b00);
    if (do_chk) begin
      check("cmd_valid", 32'(cmd_valid), 32'(insn_ready));
      check("cmd", cmd, insn_ready ? held : NOP_INSN);
      check("fetch_misalign", 32'(fetch_misalign), 32'(insn_ready && cur_pc[1:0] != 2'b00));
      check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
      if (exp_req) check("mem_req_addr", mem_req_addr, {cur_pc[31:2], 2'b00});
      check("fetch_count", fetch_count, exp_cnt);
      check("resp_at_accept", 32'(mem_resp_valid && mem_req_valid && mem_req_ready), 32'd0);
    end
    if (mem_req_valid) req_hi++;
    if (mem_req_valid && mem_req_ready) acc_cnt++;
    if (rst) begin
      insn_ready = 1'b0; accepted = 1'b0; resp_at = -1; exp_cnt = '0;
      req_age = 0; val_age = 0; acc_cnt = 0; req_hi = 0;
      cur_pc = RPC;
    end else if (insn_ready) begin
      if (cmd_ack) begin
        if (do_chk) begin
          check("accepted_reqs", 32'(acc_cnt), (cur_pc[1:0] == 2'b00) ? 32'd1 : 32'd0);
          check("req_cycles", 32'(req_hi), (cur_pc[1:0] == 2'b00) ? 32'(k_rdy + 1) : 32'd0);
        end
        exp_cnt++; commits++; last_commit = cyc;
        insn_ready = 1'b0; accepted = 1'b0;
        req_age = 0; val_age = 0; acc_cnt = 0; req_hi = 0;
        pick_next_pc();
      end else begin
        val_age++;
      end
    end else if (cur_pc[1:0] != 2'b00) begin
      insn_ready = 1'b1; held = NOP_INSN;
    end else if (!accepted) begin
      if (mem_req_ready) begin
        accepted = 1'b1; resp_at = cyc + 1 + k_rsp;
      end else begin
        req_age++;
      end
    end else if (rsp_real) begin
      insn_ready = 1'b1; held = data; resp_at = -1;
    end
    cyc++;
  endtask

  task automatic run_commits(input int n, input int budget);
    int target;
    int b;
    target = commits + n;
    b = 0;
    while (commits < target && b < budget) begin
      tick(1'b1);
      b++;
    end
    if (commits < target) check("commit_timeout", 32'(commits), 32'(target));
  endtask

  initial begin
    int c0;
    int b;
    rst = 1'b1; pc = RPC; cmd_ack = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(1'b0);
    tick(1'b0);
    rst_req = 1'b0;

    // Zero-wait fetch from the reset PC; commit lands two cycles after the first request.
    c0 = cyc;
    k_data_en = 1'b1; k_data = 32'h0010_0093;
    pc_fixed = 1'b1; pc_next = RPC + 32'd4;
    run_commits(1, 20);
    check("first_commit_cycle", 32'(last_commit - c0), 32'd2);

    // Memory stalls the request for four cycles.
    k_data_en = 1'b0; k_rdy = 4; pc_next = RPC + 32'd8;
    run_commits(1, 30);

    // Slow response, then the core withholds ack; next pc is misaligned.
    k_rdy = 0; k_rsp = 6; k_ack = 3;
    k_data_en = 1'b1; k_data = 32'hDEAD_BEEF; pc_next = RPC + 32'd2;
    run_commits(1, 30);

    // Misaligned PC: flagged NOP, no memory traffic.
    k_rsp = 0; k_ack = 0; k_data_en = 1'b0; pc_next = RPC + 32'd12;
    run_commits(1, 20);

    // Reset lands in WAIT together with the stale response.
    k_rsp = 2; k_rst_on_resp = 1'b1;
    b = 0;
    while (!saw_rst && b < 30) begin
      tick(1'b1);
      b++;
    end
    check("rst_in_wait_seen", 32'(saw_rst), 32'd1);
    k_rst_on_resp = 1'b0; k_rsp = 0;
    tick(1'b1);
    check("count_after_rst", fetch_count, 32'd0);

    // Spurious responses while an instruction is held.
    spur_pct = 100; k_ack = 3; pc_next = RPC + 32'd16;
    run_commits(1, 20);

    // Randomized traffic.
    spur_pct = 20; pc_fixed = 1'b0; k_rand = 1'b1;
    run_commits(300, 6000);
    k_rand = 1'b0;
    tick(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
